// File: rtl/rom_port_arbiter.sv
// Shares one 32-bit ROM read port between the 68k, the plane-layer gfx fetch and the sprite
// gfx fetch; one access outstanding, CPU priority with a burst cap, round-robin video, watchdog.
module rom_port_arbiter #(
  parameter int unsigned    AW        = 24,
  parameter logic [AW-1:0]  CPU_BASE  = AW'(24'h000000),
  parameter logic [AW-1:0]  TILE_BASE = AW'(24'h080000),
  parameter logic [AW-1:0]  SPR_BASE  = AW'(24'h180000),
  parameter int unsigned    CPU_BURST = 4,
  parameter int unsigned    TIMEOUT   = 255
) (
  input  logic          clk_main,
  input  logic          nRESET,
  input  logic          cpu_req,
  input  logic [22:0]   cpu_addr,
  output logic          cpu_ack,
  output logic [15:0]   cpu_data,
  input  logic          tile_req,
  input  logic [AW-1:0] tile_addr,
  output logic          tile_ack,
  input  logic          spr_req,
  input  logic [AW-1:0] spr_addr,
  output logic          spr_ack,
  output logic [31:0]   vid_data,
  output logic          err,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ready,
  input  logic          mem_valid,
  input  logic [31:0]   mem_data
);

  localparam logic [3:0] BurstMax   = 4'(CPU_BURST);
  localparam logic [7:0] TimeoutMax = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
  typedef enum logic [1:0] {OwnCpu, OwnTile, OwnSpr} owner_e;

  state_e     state_q;
  owner_e     owner_q;
  logic [3:0] burst_q;
  logic [7:0] tmo_q;
  logic       rr_spr_q;   // 0: tile has the round-robin turn, 1: sprite
  logic       cpu_lo_q;   // CPU wants the low halfword (byte address bit 1)

  logic          any_req, vid_pend, cpu_win, tile_win;
  logic [AW-1:0] cpu_sum, tile_sum, spr_sum, grant_sum;
  logic          wait_done;

  always_comb begin
    any_req  = cpu_req | tile_req | spr_req;
    vid_pend = tile_req | spr_req;
    cpu_win  = cpu_req & ((burst_q < BurstMax) | ~vid_pend);
    tile_win = ~cpu_win & tile_req & (~rr_spr_q | ~spr_req);

    cpu_sum  = CPU_BASE + AW'({cpu_addr, 1'b0});
    tile_sum = TILE_BASE + tile_addr;
    spr_sum  = SPR_BASE + spr_addr;
    if (cpu_win) begin
      grant_sum = cpu_sum;
    end else if (tile_win) begin
      grant_sum = tile_sum;
    end else begin
      grant_sum = spr_sum;
    end

    wait_done = mem_valid | ((tmo_q + 8'd1) == TimeoutMax);
  end

  always_ff @(posedge clk_main or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= StIdle;
      owner_q  <= OwnCpu;
      burst_q  <= '0;
      tmo_q    <= '0;
      rr_spr_q <= 1'b0;
      cpu_lo_q <= 1'b0;
      cpu_ack  <= 1'b0;
      tile_ack <= 1'b0;
      spr_ack  <= 1'b0;
      err      <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      cpu_data <= '0;
      vid_data <= '0;
    end else begin
      cpu_ack  <= 1'b0;
      tile_ack <= 1'b0;
      spr_ack  <= 1'b0;
      err      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            mem_addr <= {grant_sum[AW-1:2], 2'b00};
            mem_req  <= 1'b1;
            cpu_lo_q <= cpu_addr[0];
            state_q  <= StIssue;
            if (cpu_win) begin
              owner_q <= OwnCpu;
              burst_q <= vid_pend ? burst_q + 4'd1 : 4'd0;
            end else if (tile_win) begin
              owner_q  <= OwnTile;
              burst_q  <= '0;
              rr_spr_q <= 1'b1;
            end else begin
              owner_q  <= OwnSpr;
              burst_q  <= '0;
              rr_spr_q <= 1'b0;
            end
          end
        end
        StIssue: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            tmo_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (wait_done) begin
            // A timed-out access still completes, with zero data and err flagged.
            state_q <= StDone;
            err     <= ~mem_valid;
            unique case (owner_q)
              OwnCpu: begin
                cpu_ack  <= 1'b1;
                cpu_data <= !mem_valid ? 16'h0000 :
                            cpu_lo_q   ? mem_data[15:0] : mem_data[31:16];
              end
              OwnTile: begin
                tile_ack <= 1'b1;
                vid_data <= mem_valid ? mem_data : 32'h0;
              end
              default: begin
                spr_ack  <= 1'b1;
                vid_data <= mem_valid ? mem_data : 32'h0;
              end
            endcase
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
